// File: rtl/pc_flag_unit.sv
// pc_flag_unit
//   Fetch-side control stage behind the 8-bit accumulator ALU. Holds the
//   architectural carry/branch flags and owns the program counter. The PC is
//   sequenced through IDLE/RUN/HALT. Conditional branches resolve through a
//   small table of absolute targets, and a Start/Done handshake is provided.
//
//   Optional build macro: PC_FLAG_UNIT_BRCNT_EN adds a BrCount output, which
//   is a saturating 16-bit count of taken branches.
//
// Ports
//   Clk, Reset      clock (rising edge), asynchronous active-high reset
//   Start           pulse; begins a run from RESET_PC (ignored while running)
//   Halt            current instruction is HALT
//   Stall           freeze PC, flags and state this cycle
//   CmpEn/BranchIn  latch compare result into BranchFlag
//   CarryWe/CarryIn latch ALU carry_out into CarryFlag
//   BrEn/BrIdx      conditional branch through table entry BrIdx
//   LutWe/LutAddr/LutData  table write port (IDLE only)
//   PC              current instruction address
//   CarryFlag       registered carry, feeds ALU carry_in
//   BranchFlag      registered compare result
//   Running         high in RUN
//   Done            one-cycle pulse after entering HALT
//   BrCount         taken-branch count (PC_FLAG_UNIT_BRCNT_EN only)
module pc_flag_unit #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned LUT_N    = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic                       Halt,
    input  logic                       Stall,
    input  logic                       CmpEn,
    input  logic                       BranchIn,
    input  logic                       CarryWe,
    input  logic                       CarryIn,
    input  logic                       BrEn,
    input  logic [$clog2(LUT_N)-1:0]   BrIdx,
    input  logic                       LutWe,
    input  logic [$clog2(LUT_N)-1:0]   LutAddr,
    input  logic [PC_W-1:0]            LutData,
    output logic [PC_W-1:0]            PC,
    output logic                       CarryFlag,
    output logic                       BranchFlag,
    output logic                       Running,
    output logic                       Done
`ifdef PC_FLAG_UNIT_BRCNT_EN
    ,
    output logic [15:0]                BrCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] lut [LUT_N];
    logic [PC_W-1:0] pc_nxt;
    logic            carry_nxt, branch_nxt, done_nxt;
    logic            restart, active, taken;

    // Start is honoured only outside RUN; "active" is a RUN cycle not stalled.
    assign restart = Start && (state != S_RUN);
    assign active  = (state == S_RUN) && !Stall;
    // Branch decision uses the flag value from before the edge.
    assign taken   = active && !Halt && BrEn && BranchFlag;

    assign Running = (state == S_RUN);

    always_comb begin
        state_nxt  = state;
        pc_nxt     = PC;
        carry_nxt  = CarryFlag;
        branch_nxt = BranchFlag;
        done_nxt   = 1'b0;
        if (restart) begin
            state_nxt  = S_RUN;
            pc_nxt     = PC_W'(RESET_PC);
            carry_nxt  = 1'b0;
            branch_nxt = 1'b0;
        end else if (active) begin
            if (Halt) begin
                state_nxt = S_HALT;
                done_nxt  = 1'b1;
            end else if (taken) begin
                pc_nxt     = lut[BrIdx];
                branch_nxt = 1'b0;
            end else begin
                pc_nxt = PC + PC_W'(1);
            end
            // A compare in the same cycle overrides the consumed flag.
            if (CmpEn)
                branch_nxt = BranchIn;
            if (CarryWe)
                carry_nxt = CarryIn;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            PC         <= PC_W'(RESET_PC);
            CarryFlag  <= 1'b0;
            BranchFlag <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            PC         <= pc_nxt;
            CarryFlag  <= carry_nxt;
            BranchFlag <= branch_nxt;
            Done       <= done_nxt;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < LUT_N; i++)
                lut[i] <= '0;
        end else if (LutWe && (state == S_IDLE)) begin
            lut[LutAddr] <= LutData;
        end
    end

`ifdef PC_FLAG_UNIT_BRCNT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            BrCount <= '0;
        else if (restart)
            BrCount <= '0;
        else if (taken && (BrCount != '1))
            BrCount <= BrCount + 16'd1;
    end
`endif

endmodule

// File: doc/pc_flag_unit.md
Name: pc_flag_unit

Overview:
- Fetch-side control stage directly downstream of the 8-bit accumulator ALU.
- Consumes the ALU's `branch` and `carry_out` results and holds them in architectural flag registers. The registered carry flag is fed back as the ALU's `carry_in`.
- Owns the program counter: sequences it through IDLE/RUN/HALT, resolves branches through an 8-entry target table, and provides a start/done handshake to the testbench/top level.

Parameters:
- PC_W, 10, program counter width (instruction memory depth 2^PC_W).
- LUT_N, 8, number of branch-target table entries (index width = clog2(LUT_N) = 3).
- RESET_PC, 0, PC value loaded on reset and on Start.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  pulse; begins a program run from RESET_PC.
- Halt  in  1  decoder: current instruction is HALT.
- Stall  in  1  freeze PC and flags this cycle.
- CmpEn  in  1  decoder: current instruction is a compare; latch BranchIn.
- BranchIn  in  1  ALU `branch` output.
- CarryWe  in  1  decoder: current instruction writes carry.
- CarryIn  in  1  ALU `carry_out`.
- BrEn  in  1  decoder: current instruction is a conditional branch.
- BrIdx  in  3  branch-target table index.
- LutWe  in  1  table write enable (legal in IDLE only).
- LutAddr  in  3  table write address.
- LutData  in  PC_W  table write data (absolute target PC).
- PC  out  PC_W  current instruction address.
- CarryFlag  out  1  registered carry; drives ALU `carry_in`.
- BranchFlag  out  1  registered compare result.
- Running  out  1  high in RUN.
- Done  out  1  one-cycle pulse on RUN->HALT.

Behaviour:
- Reset (async): PC=RESET_PC, CarryFlag=0, BranchFlag=0, state=IDLE, Done=0, all table entries=0. Reset mid-run aborts immediately; no Done pulse is produced.
- IDLE:
  - PC holds. Table writes allowed: on LutWe, entry[LutAddr] <= LutData next edge.
  - Start -> RUN, with PC <= RESET_PC, CarryFlag <= 0, BranchFlag <= 0.
- RUN, per edge, when Stall=0. Priority is Halt > BrEn > increment:
  - Halt: -> HALT. PC holds. Done=1 for exactly one cycle.
  - BrEn with BranchFlag=1: PC <= entry[BrIdx]. BranchFlag <= 0 (consumed).
  - BrEn with BranchFlag=0: PC <= PC+1.
  - Otherwise: PC <= PC+1. Wraps modulo 2^PC_W (all-ones -> 0); no error flag.
  - Branch decision uses the flag value before the edge. CmpEn and BrEn in the same cycle is illegal; if it occurs, BrEn uses the old flag and CmpEn then overwrites the flag.
- Flags in RUN, when Stall=0:
  - CmpEn: BranchFlag <= BranchIn.
  - CarryWe: CarryFlag <= CarryIn.
  - Both are independent and may occur in the same cycle.
- Stall=1 in RUN: PC, flags and state all hold. Halt, BrEn, CmpEn and CarryWe are ignored that cycle.
- HALT:
  - PC and flags hold; Running=0.
  - Start -> RUN (restart as from IDLE).
  - Table writes are ignored. LutWe outside IDLE has no effect.
- Start while in RUN is ignored.
- Latency:
  - PC changes one edge after the qualifying input.
  - Flags are visible one edge after CmpEn/CarryWe.
  - Done is asserted the cycle after the edge that enters HALT.
- Outputs are registered (Running is decoded from state).

Optional Feature:
- Macro PC_FLAG_UNIT_BRCNT_EN.
- Defined:
  - Extra output port BrCount (16 bits), counting taken branches. Saturates at 16'hFFFF.
  - Cleared on Reset and on Start; holds during Stall and HALT.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset during RUN at PC=0x025 -> PC=0x000, flags 0, state IDLE next cycle, no Done pulse.
- Load entry[3]=0x1A0; Start; run 5 cycles; CmpEn with BranchIn=1; next cycle BrEn, BrIdx=3 -> PC=0x1A0, BranchFlag=0. Repeat with BranchIn=0 -> PC increments by 1.
- CarryWe with CarryIn=1 and CmpEn with BranchIn=1 in the same cycle -> CarryFlag=1 and BranchFlag=1 next edge. Then Stall=1 for 3 cycles with CarryWe, CarryIn=0 -> CarryFlag remains 1 and PC is unchanged.
- Table entry=0x3FF; branch taken -> PC=0x3FF; next increment -> PC=0x000 (wrap).
- Halt and BrEn in the same cycle at PC=0x010 -> state HALT, PC=0x010, Done high exactly one cycle. Then Start -> PC=0x000, Running=1.
- With PC_FLAG_UNIT_BRCNT_EN: 3 taken branches and 2 not-taken branches -> BrCount=3. Start -> BrCount=0.
